// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Converts a spike train into a rate code. The decoder counts spikes over a
// fixed window of WINDOW enabled clock cycles and presents each window's count
// through a one-entry valid/ready output register. If the consumer has not
// taken the previous count when a new window completes, the new count is
// dropped and a sticky overrun flag is raised.
//
// Parameters
//   WINDOW      integration window length in enabled cycles (legal 2..256)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset, overrides every other input
//   en          window counting enable; counters hold while low
//   spike_in    spike train, one spike per high cycle
//   clr_ovr     clears the overrun flag (a same-edge set wins)
//   rate_ready  consumer ready for rate_out
//   rate_out    spike count of the last completed window (saturates at 255)
//   rate_valid  rate_out holds an unconsumed result
//   overrun     sticky: a completed window result was discarded
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       spike_in,
  input  logic       clr_ovr,
  input  logic       rate_ready,
  output logic [7:0] rate_out,
  output logic       rate_valid,
  output logic       overrun
);

  localparam int            CW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [CW-1:0] cyc;
  logic [7:0]  acc;
  logic        window_end;
  logic [7:0]  win_result;
  logic        load;
  logic        ovr_set;

  // ---------------------------------------------------------------------------
  // Window counting
  // ---------------------------------------------------------------------------
  assign window_end = en && (cyc == LAST);

  // The final cycle's spike belongs to the ending window, so it is folded in
  // here instead of going through acc (which is cleared on the same edge).
  assign win_result = (acc == 8'hFF) ? 8'hFF : (acc + {7'b0, spike_in});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
      acc <= '0;
    end else if (en) begin
      if (window_end) begin
        cyc <= '0;
        acc <= '0;
      end else begin
        cyc <= cyc + 1'b1;
        if (spike_in && (acc != 8'hFF)) begin
          acc <= acc + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: one-entry holding register with valid/ready handshake
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      EMPTY: begin
        if (window_end) begin
          state_d = FULL;
          load    = 1'b1;
        end
      end
      FULL: begin
        if (window_end) begin
          // Consumer takes the old result on this edge: replace it in place.
          // Otherwise the old result is still owed, so the new one is lost.
          if (rate_ready) begin
            load = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end else if (rate_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rate_out <= '0;
      overrun  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rate_out <= win_result;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Decoded straight from the state register, so still free of any
  // combinational path from the inputs.
  assign rate_valid = (state_q == FULL);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Scoreboard bench for spike_rate_decoder (WINDOW=16), plus a second instance
// with WINDOW=256 fed a constant spike train to exercise count saturation.
// The driver computes expected behaviour from an abstract model (total spikes
// per window, min'd with 255; a single pending-result slot) and queues it; an
// independent monitor compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

  localparam int WIN = 16;

  typedef struct {
    bit      valid;
    bit      ovr;
    int      out;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       spike_in;
  logic       clr_ovr;
  logic       rate_ready;
  logic [7:0] rate_out;
  logic       rate_valid;
  logic       overrun;

  logic       sat_rst;
  logic       sat_en;
  logic       sat_spike;
  logic       sat_clr;
  logic       sat_ready;
  logic [7:0] sat_out;
  logic       sat_valid;
  logic       sat_ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int sat_seen = 0;

  exp_t state_q[$];
  int   res_q[$];

  // Abstract model state
  int m_pos, m_spikes, m_out;
  bit m_full, m_ovr;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .clr_ovr    (clr_ovr),
    .rate_ready (rate_ready),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .overrun    (overrun)
  );

  spike_rate_decoder #(.WINDOW(256)) dut_sat (
    .clk        (clk),
    .rst        (sat_rst),
    .en         (sat_en),
    .spike_in   (sat_spike),
    .clr_ovr    (sat_clr),
    .rate_ready (sat_ready),
    .rate_out   (sat_out),
    .rate_valid (sat_valid),
    .overrun    (sat_ovr)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs applied to it.
  task automatic model_edge();
    bit wend;
    bit set;
    int res;
    wend = 0;
    set  = 0;
    res  = 0;
    if (rst) begin
      m_pos = 0; m_spikes = 0; m_full = 0; m_ovr = 0; m_out = 0;
    end else begin
      if (en) begin
        m_spikes += int'(spike_in);
        if (m_pos == WIN - 1) begin
          wend     = 1;
          res      = (m_spikes > 255) ? 255 : m_spikes;
          m_spikes = 0;
          m_pos    = 0;
        end else begin
          m_pos++;
        end
      end
      if (wend) begin
        if (!m_full || rate_ready) begin
          m_full = 1;
          m_out  = res;
          res_q.push_back(res);
        end else begin
          set = 1;
        end
      end else if (rate_ready) begin
        m_full = 0;
      end
      if (set) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
    end
    state_q.push_back('{valid: m_full, ovr: m_ovr, out: m_out});
  endtask

  // Apply one cycle of inputs, let the edge happen, record the expectation.
  task automatic step(input logic e, input logic s, input logic r,
                      input logic c, input logic x);
    en = e; spike_in = s; rate_ready = r; clr_ovr = c; rst = x;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic window(input logic [15:0] pat, input logic ready_all,
                        input logic ready_last);
    for (int i = 0; i < WIN; i++) begin
      step(1'b1, pat[i], (i == WIN - 1) ? ready_last : ready_all, 1'b0, 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit prev_valid = 0;
  bit prev_ready = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (state_q.size() > 0) begin
        exp_t e;
        bit   pres;
        e = state_q.pop_front();
        check("rate_valid", int'(rate_valid), int'(e.valid));
        check("overrun", int'(overrun), int'(e.ovr));
        check("rate_out", int'(rate_out), e.out);
        // A new result is on offer when valid rises or after a handshake
        // that left valid high.
        pres = rate_valid && (!prev_valid || prev_ready);
        if (pres) begin
          if (res_q.size() == 0) begin
            check("result_underflow", 1, 0);
          end else begin
            check("result", int'(rate_out), res_q.pop_front());
          end
        end
        prev_valid = rate_valid;
        prev_ready = rate_ready;
      end
      if (sat_valid) begin
        sat_seen++;
        check("sat_rate_out", int'(sat_out), 255);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    sat_rst = 1'b1; sat_en = 1'b1; sat_spike = 1'b1; sat_clr = 1'b0; sat_ready = 1'b1;
    m_pos = 0; m_spikes = 0; m_out = 0; m_full = 0; m_ovr = 0;

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    sat_rst = 1'b0;

    // 5 spikes, consumer always ready: one-cycle valid pulse
    window(16'h8425, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Constant spikes: every window counts 16
    window(16'hFFFF, 1'b1, 1'b1);
    window(16'hFFFF, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Overrun: 3 pending, 7 dropped, then clear
    window(16'h8104, 1'b0, 1'b0);
    window(16'h80FC, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Ready exactly on the final edge of window 2: replace, no overrun
    window(16'h8104, 1'b0, 1'b0);
    window(16'h80FC, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Same-edge overrun set and clear: set wins
    window(16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < WIN; i++) begin
      step(1'b1, 1'b0, 1'b0, (i == WIN - 1) ? 1'b1 : 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Enable gap of 10 cycles with spikes held high
    for (int i = 0; i < WIN; i++) begin
      logic [15:0] pat;
      pat = 16'h0F0F;
      if (i == 6) begin
        for (int g = 0; g < 10; g++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, pat[i], 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-window with a result pending
    window(16'h0011, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    window(16'h0003, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    // Drain monitor and close out
    @(negedge clk);
    @(negedge clk);
    check("expect_queue_drained", state_q.size(), 0);
    check("results_consumed", res_q.size(), 0);
    check("sat_window_seen", (sat_seen > 0) ? 1 : 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
